// File: rtl/dc_seq_pkg.sv
// Shared types for the dc_seq microsequencer: FSM states, next-address select codes,
// and the return-address helper.
package dc_seq_pkg;

    localparam int unsigned AW = 10;
    localparam int unsigned MW = 9;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_TRAP = 3'd1,
        SEL_SWAP = 3'd2,
        SEL_RET  = 3'd3,
        SEL_PLA  = 3'd4,
        SEL_CALL = 3'd5,
        SEL_SEQ  = 3'd6
    } sel_e;

    // Return address keeps the AX bank bit and wraps within the 9-bit page
    function automatic logic [AW-1:0] ret_addr(input logic [AW-1:0] a);
        return {a[AW-1], a[MW-1:0] + MW'(1)};
    endfunction

endpackage

// File: rtl/dc_seq_stk.sv
// Microcall return stack: entry 0 is the top; a push when full drops the oldest entry.
module dc_seq_stk
    import dc_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          swap,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] mem_d [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (swap) begin
            mem_d[0] = din;
        end else if (push) begin
            for (int i = int'(DEPTH) - 1; i > 0; i--) begin
                mem_d[i] = mem_q[i-1];
            end
            mem_d[0] = din;
            if (cnt_q != CW'(DEPTH)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop && (cnt_q != '0)) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            mem_d[DEPTH-1] = '0;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    assign top   = mem_q[0];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/dc_seq.sv
// MicROM next-address sequencer with call/return stack and decode entry.
// Trap vectoring is compiled in only when F11_SEQ_TRAP_EN is defined.
module dc_seq
    import dc_seq_pkg::*;
#(
    parameter logic [AW-1:0] RST_ADDR  = 10'h000,
    parameter logic [AW-1:0] TRAP_BASE = 10'h1F0,
    parameter int unsigned   STK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          ax,
    input  logic [MW-1:0] ma,
    input  logic          call,
    input  logic          ret,
    input  logic          pla_vld,
    input  logic [MW-1:0] pla_addr,
    input  logic          trap_req,
    input  logic [3:0]    trap_vec,
    output logic [AW-1:0] rom_a,
    output logic          rom_cen,
    output logic          trap_ack,
    output logic          stk_err,
    output logic          run
);

    state_e        state_q, state_d;
    sel_e          sel;
    logic [AW-1:0] rom_a_q, rom_a_d;
    logic          trap_ack_q, trap_ack_d;
    logic          stk_err_q, err_set;
    logic          run_q, run_d;
    logic          push, pop, swap;
    logic [AW-1:0] stk_din, stk_top;
    logic          stk_empty, stk_full;
    logic          trap_hit;
    logic [AW-1:0] trap_addr;
    logic [AW-1:0] seq_a;

`ifdef F11_SEQ_TRAP_EN
    assign trap_hit  = trap_req;
    assign trap_addr = TRAP_BASE | AW'(trap_vec);
`else
    logic unused_trap;
    assign trap_hit    = 1'b0;
    assign trap_addr   = '0;
    assign unused_trap = ^{trap_req, trap_vec, TRAP_BASE};
`endif

    assign seq_a = {ax, ma};

    // Next state, next-address select and stack control
    always_comb begin
        state_d    = state_q;
        sel        = SEL_HOLD;
        rom_a_d    = rom_a_q;
        trap_ack_d = 1'b0;
        run_d      = 1'b0;
        err_set    = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        swap       = 1'b0;
        stk_din    = ret_addr(rom_a_q);

        case (state_q)
            ST_RST: state_d = ST_PRIME;
            ST_PRIME: begin
                if (!stall) begin
                    state_d = ST_RUN;
                    run_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    run_d = 1'b1;
                    if (trap_hit)          sel = SEL_TRAP;
                    else if (ret && call)  sel = SEL_SWAP;
                    else if (ret)          sel = SEL_RET;
                    else if (pla_vld)      sel = SEL_PLA;
                    else if (call)         sel = SEL_CALL;
                    else                   sel = SEL_SEQ;
                end
            end
            default: state_d = ST_RST;
        endcase

        case (sel)
            SEL_TRAP: begin
                rom_a_d    = trap_addr;
                stk_din    = seq_a;
                push       = 1'b1;
                err_set    = stk_full;
                trap_ack_d = 1'b1;
            end
            SEL_SWAP: begin
                // With nothing to return to, behave as an underflowing return that still records the call
                if (stk_empty) begin
                    rom_a_d = RST_ADDR;
                    push    = 1'b1;
                    err_set = 1'b1;
                end else begin
                    rom_a_d = stk_top;
                    swap    = 1'b1;
                end
            end
            SEL_RET: begin
                if (stk_empty) begin
                    rom_a_d = RST_ADDR;
                    err_set = 1'b1;
                end else begin
                    rom_a_d = stk_top;
                    pop     = 1'b1;
                end
            end
            SEL_PLA:  rom_a_d = {1'b0, pla_addr};
            SEL_CALL: begin
                rom_a_d = seq_a;
                push    = 1'b1;
                err_set = stk_full;
            end
            SEL_SEQ:  rom_a_d = seq_a;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RST;
            rom_a_q    <= RST_ADDR;
            trap_ack_q <= 1'b0;
            stk_err_q  <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_a_q    <= rom_a_d;
            trap_ack_q <= trap_ack_d;
            stk_err_q  <= stk_err_q | err_set;
            run_q      <= run_d;
        end
    end

    dc_seq_stk #(
        .DEPTH (STK_DEPTH)
    ) u_stk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .swap  (swap),
        .din   (stk_din),
        .top   (stk_top),
        .empty (stk_empty),
        .full  (stk_full)
    );

    assign rom_a    = rom_a_q;
    assign rom_cen  = (state_q != ST_RST) && !stall;
    assign trap_ack = trap_ack_q;
    assign stk_err  = stk_err_q;
    assign run      = run_q;

endmodule

// File: tb/tb_dc_seq.sv
// Self-checking bench for dc_seq: vector table through a scoreboard queue plus
// hand sequences for reset, stack overflow/underflow and trap priority.
module tb_dc_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0;
    logic       ax = 1'b0;
    logic [8:0] ma = '0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic       pla_vld = 1'b0;
    logic [8:0] pla_addr = '0;
    logic       trap_req = 1'b0;
    logic [3:0] trap_vec = '0;
    logic [9:0] rom_a;
    logic       rom_cen;
    logic       trap_ack;
    logic       stk_err;
    logic       run;

    int n_chk = 0;
    int n_err = 0;
    int step_no = 0;

    typedef struct {
        logic       st;
        logic       ax;
        logic [8:0] ma;
        logic       call;
        logic       ret;
        logic       pla;
        logic [8:0] paddr;
        logic       trq;
        logic [3:0] tvec;
        logic [9:0] ea;
        logic       eack;
        logic       eerr;
        logic       erun;
    } vec_t;

    typedef struct {
        logic [9:0] a;
        logic       ack;
        logic       err;
        logic       run;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];

    dc_seq u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .ax       (ax),
        .ma       (ma),
        .call     (call),
        .ret      (ret),
        .pla_vld  (pla_vld),
        .pla_addr (pla_addr),
        .trap_req (trap_req),
        .trap_vec (trap_vec),
        .rom_a    (rom_a),
        .rom_cen  (rom_cen),
        .trap_ack (trap_ack),
        .stk_err  (stk_err),
        .run      (run)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", nm, step_no, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic a9, input logic [8:0] m,
                                input logic c, input logic r, input logic p,
                                input logic [8:0] pa, input logic tq, input logic [3:0] tv,
                                input logic [9:0] ea, input logic eack, input logic eerr,
                                input logic erun);
        vec_t v;
        v.st = st; v.ax = a9; v.ma = m; v.call = c; v.ret = r; v.pla = p;
        v.paddr = pa; v.trq = tq; v.tvec = tv;
        v.ea = ea; v.eack = eack; v.eerr = eerr; v.erun = erun;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        stall = v.st; ax = v.ax; ma = v.ma; call = v.call; ret = v.ret;
        pla_vld = v.pla; pla_addr = v.paddr; trap_req = v.trq; trap_vec = v.tvec;
        #1;
        chk("rom_cen", 10'(rom_cen), 10'(!v.st));
        sbq.push_back('{a: v.ea, ack: v.eack, err: v.eerr, run: v.erun});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("rom_a", rom_a, e.a);
        chk("trap_ack", 10'(trap_ack), 10'(e.ack));
        chk("stk_err", 10'(stk_err), 10'(e.err));
        chk("run", 10'(run), 10'(e.run));
        step_no++;
    endtask

    // Reset with requests pending, then release and walk RST -> PRIME -> RUN
    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b1; call = 1'b1; ret = 1'b1; pla_vld = 1'b1; trap_req = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rom_a", rom_a, 10'h000);
        chk("rst_rom_cen", 10'(rom_cen), 10'h0);
        chk("rst_run", 10'(run), 10'h0);
        chk("rst_stk_err", 10'(stk_err), 10'h0);
        chk("rst_trap_ack", 10'(trap_ack), 10'h0);
        stall = 1'b0; call = 1'b0; ret = 1'b0; pla_vld = 1'b0; trap_req = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("cyc1_rom_cen", 10'(rom_cen), 10'h0);
        @(posedge clk);
        #1;
        chk("cyc2_rom_cen", 10'(rom_cen), 10'h1);
        chk("cyc2_rom_a", rom_a, 10'h000);
        chk("cyc2_run", 10'(run), 10'h0);
        @(posedge clk);
        #1;
        chk("cyc3_rom_cen", 10'(rom_cen), 10'h1);
        chk("cyc3_run", 10'(run), 10'h1);
        step_no++;
    endtask

    initial begin
        // st ax ma call ret pla paddr trq tvec -> rom_a ack err run
        tbl.push_back(mk(0, 0, 9'h045, 0, 0, 0, 9'h000, 0, 4'h0, 10'h045, 0, 0, 1));
        tbl.push_back(mk(0, 0, 9'h120, 1, 0, 0, 9'h000, 0, 4'h0, 10'h120, 0, 0, 1));
        tbl.push_back(mk(0, 0, 9'h121, 0, 0, 0, 9'h000, 0, 4'h0, 10'h121, 0, 0, 1));
        tbl.push_back(mk(0, 0, 9'h1FF, 0, 1, 0, 9'h000, 0, 4'h0, 10'h046, 0, 0, 1));
        tbl.push_back(mk(0, 1, 9'h07A, 0, 0, 0, 9'h000, 0, 4'h0, 10'h27A, 0, 0, 1));
        tbl.push_back(mk(0, 1, 9'h011, 1, 0, 1, 9'h155, 0, 4'h0, 10'h155, 0, 0, 1));
        tbl.push_back(mk(1, 0, 9'h100, 1, 0, 0, 9'h000, 0, 4'h0, 10'h155, 0, 0, 0));
        tbl.push_back(mk(1, 0, 9'h100, 1, 0, 0, 9'h000, 0, 4'h0, 10'h155, 0, 0, 0));
        tbl.push_back(mk(1, 0, 9'h100, 1, 0, 0, 9'h000, 0, 4'h0, 10'h155, 0, 0, 0));
        tbl.push_back(mk(0, 0, 9'h033, 1, 0, 0, 9'h000, 0, 4'h0, 10'h033, 0, 0, 1));
        tbl.push_back(mk(0, 0, 9'h050, 1, 1, 0, 9'h000, 0, 4'h0, 10'h156, 0, 0, 1));
        tbl.push_back(mk(0, 0, 9'h000, 0, 1, 0, 9'h000, 0, 4'h0, 10'h034, 0, 0, 1));
        tbl.push_back(mk(0, 0, 9'h000, 0, 1, 0, 9'h000, 0, 4'h0, 10'h000, 0, 1, 1));
        tbl.push_back(mk(0, 1, 9'h1FE, 0, 0, 0, 9'h000, 0, 4'h0, 10'h3FE, 0, 1, 1));
        tbl.push_back(mk(0, 0, 9'h0AA, 1, 0, 0, 9'h000, 0, 4'h0, 10'h0AA, 0, 1, 1));
        tbl.push_back(mk(0, 0, 9'h000, 0, 1, 0, 9'h000, 0, 4'h0, 10'h3FF, 0, 1, 1));
        tbl.push_back(mk(0, 0, 9'h010, 1, 0, 0, 9'h000, 0, 4'h0, 10'h010, 0, 1, 1));
        tbl.push_back(mk(0, 0, 9'h000, 0, 1, 0, 9'h000, 0, 4'h0, 10'h200, 0, 1, 1));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Reset mid-operation clears the sticky error and restarts the pipeline
        do_reset();

        // Five nested calls into a four-deep stack, then five returns
        for (int k = 0; k < 5; k++) begin
            apply(mk(0, 0, 9'(16 * (k + 1)), 1, 0, 0, 9'h000, 0, 4'h0,
                     10'(16 * (k + 1)), 0, (k == 4), 1));
        end
        for (int j = 0; j < 4; j++) begin
            apply(mk(0, 0, 9'h000, 0, 1, 0, 9'h000, 0, 4'h0, 10'(16 * (4 - j) + 1), 0, 1, 1));
        end
        apply(mk(0, 0, 9'h000, 0, 1, 0, 9'h000, 0, 4'h0, 10'h000, 0, 1, 1));

        // Trap while stalled is ignored
        apply(mk(1, 0, 9'h000, 0, 0, 0, 9'h000, 1, 4'h3, 10'h000, 0, 1, 0));
        apply(mk(0, 0, 9'h0AB, 1, 0, 0, 9'h000, 0, 4'h0, 10'h0AB, 0, 1, 1));
`ifdef F11_SEQ_TRAP_EN
        apply(mk(0, 0, 9'h0DD, 0, 1, 1, 9'h0CC, 1, 4'h3, 10'h1F3, 1, 1, 1));
        apply(mk(0, 0, 9'h0EE, 0, 0, 0, 9'h000, 0, 4'h0, 10'h0EE, 0, 1, 1));
        apply(mk(0, 0, 9'h000, 0, 1, 0, 9'h000, 0, 4'h0, 10'h0DD, 0, 1, 1));
        apply(mk(0, 0, 9'h000, 0, 1, 0, 9'h000, 0, 4'h0, 10'h001, 0, 1, 1));
        apply(mk(0, 0, 9'h000, 0, 1, 0, 9'h000, 0, 4'h0, 10'h000, 0, 1, 1));
        apply(mk(0, 0, 9'h0A5, 0, 0, 0, 9'h000, 1, 4'h7, 10'h1F7, 1, 1, 1));
`else
        apply(mk(0, 0, 9'h0DD, 0, 1, 1, 9'h0CC, 1, 4'h3, 10'h001, 0, 1, 1));
        apply(mk(0, 0, 9'h0EE, 0, 0, 0, 9'h000, 0, 4'h0, 10'h0EE, 0, 1, 1));
        apply(mk(0, 0, 9'h000, 0, 1, 0, 9'h000, 0, 4'h0, 10'h000, 0, 1, 1));
        apply(mk(0, 0, 9'h000, 0, 1, 0, 9'h000, 0, 4'h0, 10'h000, 0, 1, 1));
        apply(mk(0, 0, 9'h000, 0, 1, 0, 9'h000, 0, 4'h0, 10'h000, 0, 1, 1));
        apply(mk(0, 0, 9'h0A5, 0, 0, 0, 9'h000, 1, 4'h7, 10'h0A5, 0, 1, 1));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dc_seq.md
DC_SEQ -- requirements
Module: dc_seq

Interface
REQ-001 SHALL have parameter RST_ADDR, default 10'h000, microaddress fetched first after reset.
REQ-002 SHALL have parameter TRAP_BASE, default 10'h1F0, trap vector base (low 4 bits zero).
REQ-003 SHALL have parameter STK_DEPTH, default 4, return stack entries (2..8).
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have port stall  in  1  hold current microaddress, no ROM read.
REQ-007 SHALL have port ax  in  1  AX extension select, drives rom_a[9] of next fetch.
REQ-008 SHALL have port ma  in  9  next-address field from MicROM (valid the cycle after a read).
REQ-009 SHALL have port call  in  1  decoded microcall: jump to ma, push return.
REQ-010 SHALL have port ret  in  1  decoded microreturn: jump to stack top, pop.
REQ-011 SHALL have port pla_vld  in  1  instruction decode entry available.
REQ-012 SHALL have port pla_addr  in  9  decode entry address (rom_a[9] forced 0).
REQ-013 SHALL have ports trap_req  in  1 and trap_vec  in  4  trap request and vector.
REQ-014 SHALL have port rom_a  out  10  registered MicROM address.
REQ-015 SHALL have port rom_cen  out  1  MicROM read enable.
REQ-016 SHALL have ports trap_ack  out  1 (one-cycle pulse), stk_err  out  1 (sticky), run  out  1 (ROM output valid).

Function
REQ-017 SHALL implement FSM RST -> PRIME -> RUN; RST one cycle after rst_n high, PRIME issues read of RST_ADDR, RUN thereafter.
REQ-018 SHALL assert rom_cen = ~stall in PRIME and RUN, 0 in RST.
REQ-019 SHALL, in RUN with stall=0, load rom_a by priority: trap, ret, pla_vld, call/plain (ma); next address visible one cycle later, ROM data two cycles later.
REQ-020 SHALL set rom_a = {ax, ma} for plain and call transitions, {1'b0, pla_addr} for decode, TRAP_BASE | trap_vec for trap.
REQ-021 SHALL, on call, push {rom_a[9], rom_a[8:0]+1} (9-bit wrap) of the current address.
REQ-022 SHALL, on trap, push {ax, ma} (the address otherwise taken) and pulse trap_ack for one cycle.
REQ-023 SHALL, on call and ret together, jump to stack top and replace top with the call return address (no depth change).
REQ-024 SHALL, on ret with empty stack, jump to RST_ADDR and set stk_err.
REQ-025 SHALL, on push with full stack, discard the oldest entry and set stk_err.
REQ-026 SHALL ignore call, ret, pla_vld, trap_req and hold rom_a, the stack and trap_ack=0 while stall=1 or state is not RUN.
REQ-027 SHALL assert run only in RUN with the previous cycle a non-stalled read.

Reset
REQ-028 SHALL, with rst_n=0 at a clock edge, set state RST, rom_a=RST_ADDR, rom_cen=0, stack empty, stk_err=0, trap_ack=0, run=0, regardless of stall or pending requests.
REQ-029 SHALL discard any in-flight ROM data on reset mid-operation (run low until PRIME completes).

Configuration
REQ-030 SHALL compile trap logic only when F11_SEQ_TRAP_EN is defined; without it trap_req/trap_vec are ignored, trap_ack is tied 0, and priority is ret, pla_vld, call/plain.

Structure
REQ-031 SHALL place the FSM state encoding and the priority-select encoding in shared package dc_seq_pkg.
REQ-032 SHALL implement the return stack as sub-module dc_seq_stk (push, pop, swap, empty, full).

Verification
REQ-033 SHALL cover reset: release rst_n -> rom_a=000, rom_cen 0,1,1; run first high on cycle 3.
REQ-034 SHALL cover call/ret: at 10'h045, call with ma=9'h120 -> rom_a=120; later ret -> rom_a=046, stack empty.
REQ-035 SHALL cover overflow/underflow: five nested calls (depth 4) -> stk_err=1, fifth ret -> rom_a=RST_ADDR.
REQ-036 SHALL cover trap priority: trap_req, trap_vec=3, pla_vld and ret all high -> rom_a=1F3, trap_ack pulse, stack depth +1.
REQ-037 SHALL cover stall: stall high 3 cycles with call asserted -> rom_a and stack unchanged, rom_cen 0.
REQ-038 SHALL cover AX and build option: ax=1, ma=9'h07A -> rom_a=27A; without F11_SEQ_TRAP_EN, trap_req ignored.
